adc_capture_ctrl: RTL and testbench
===================================

// Module: adc_capture_ctrl
// PURPOSE
// - Downstream of the AD5664 DAC scan controller: one ADC sample per scan position after all 4 DAC channels are written.
// - Per pixel: pulses convert, reads one serial word over 3-wire SPI, tags it with the scan index and frame start.
// - Buffers tagged words in a small FIFO and offers them on a valid/ready stream to the frame-store/host link.
// PARAMETERS
// - DATA_W      16    ADC result width, MSB first on adc_sdo
// - T_CONV      40    cycles adc_cnv is held high (conversion time)
// - FIFO_DEPTH  4     output FIFO entries, power of two, >=2
// - IDX_W       12    pixel index width, taken from verti_counter[IDX_W-1:0]
// PORTS
// - rx_spi_sclk_wire  in   1       sole clock; same source as the DAC SPI clock
// - rst               in   1       async reset, active-low
// - adc_start         in   1       DAC init done, pixel stream live
// - serial_counter    in   4       DAC channel-write count; ==4 means pixel settled
// - verti_counter     in   32      current scan position
// - loop              in   1       high while the DAC is at the frame corner
// - adc_cnv           out  1       ADC convert strobe
// - adc_cs_n          out  1       ADC chip select, active-low
// - adc_sck           out  1       ADC serial clock, clk/2, idles low
// - adc_sdo           in   1       ADC serial data
// - smp_data          out  DATA_W  head-of-FIFO sample
// - smp_index         out  IDX_W   pixel index of smp_data
// - smp_sof           out  1       smp_data is the first pixel of a frame
// - smp_valid         out  1       FIFO non-empty
// - smp_ready         in   1       consumer accepts when valid&&ready
// - ovf_err           out  1       sticky: completed sample dropped, FIFO full
// - miss_err          out  1       sticky: trigger arrived while FSM busy
// BEHAVIOUR
// - Reset (rst low, async): FSM IDLE; adc_cnv=0, adc_cs_n=1, adc_sck=0, smp_valid=0, smp_data/index/sof=0, errors=0, FIFO empty, sync chain cleared.
// - Trigger: flag (serial_counter==4) passes a 2-FF synchroniser; trig = rising edge of the synced flag && adc_start && !loop.
// - Index/frame latch: on trig, idx <= verti_counter[IDX_W-1:0]; sof <= (verti_counter==0).
// - FSM states / transitions:
//   IDLE -> CONV on trig.
//   CONV: adc_cnv=1 for exactly T_CONV cycles -> ACQ.
//   ACQ: adc_cs_n=0; adc_sck toggles every cycle, starting low.
//     adc_sdo sampled on the cycle adc_sck goes 0->1; shifted into an MSB-first register.
//     After DATA_W samples: adc_sck returns low, adc_cs_n=1 -> PUSH.
//   PUSH (1 cycle): write {sof,idx,data} to FIFO if not full, else drop it and set ovf_err -> IDLE.
// - Latency: trig to FIFO write = T_CONV + 2*DATA_W + 1 cycles; write to smp_valid = 1 cycle.
// - A trig outside IDLE is ignored and sets miss_err. Sticky errors clear only on reset.
// - FIFO:
//   - First-word-fall-through; smp_* reflect the head entry.
//   - Simultaneous push and pop when full is accepted; count stays unchanged, no ovf.
//   - Pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
// - adc_start falling mid-capture does not abort; the current word completes.
// - Reset mid-ACQ: adc_cs_n rises immediately; the partial word is discarded.
// - loop high suppresses new triggers; the frame-corner pixel is never sampled.
// STRUCTURE
// - Package adc_capture_pkg: FSM state encoding (IDLE, CONV, ACQ, PUSH), DATA_W/IDX_W defaults, FIFO entry width = 1+IDX_W+DATA_W.
// - Sub-module adc_sample_fifo:
//   - Generic sync FWFT FIFO with width and depth parameters.
//   - Ports: push, pop, wdata, rdata, full, empty.
// - Top holds the synchroniser, trigger edge detect, FSM, conversion/bit counters, shift register and sticky flags.
// TESTING
// - Single pixel: adc_start=1, serial_counter 3->4, verti_counter=5, ADC model returns 16'hA5C3.
//   Expect smp_data=A5C3, smp_index=5, smp_sof=0, valid after 74 cycles.
//   Expect exactly 16 adc_sck rising edges.
// - Frame start: verti_counter=0 on trigger -> smp_sof=1. verti_counter=1999, loop=1 -> no capture, no miss_err.
// - Back-pressure: smp_ready=0, 5 pixels -> 4 words held, ovf_err=1 after 5th PUSH.
//   Then ready=1 -> indices drain in order 0,1,2,3.
// - Busy trigger: second serial_counter==4 edge 10 cycles into CONV -> miss_err=1, single FIFO word.
// - Full+pop: FIFO full, ready=1 during PUSH -> count stays 4, ovf_err=0, ordering intact.
// - Async reset mid-ACQ (bit 7): adc_cs_n=1, adc_sck=0 immediately, FIFO empty, no word emitted after release.

Source files
------------

// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg
// Shared definitions for the ADC capture controller: FSM state encoding,
// default widths/timing and the FIFO entry width helper.
package adc_capture_pkg;

    localparam int unsigned DataWDef     = 16;
    localparam int unsigned IdxWDef      = 12;
    localparam int unsigned TConvDef     = 40;
    localparam int unsigned FifoDepthDef = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StConv = 2'd1,
        StAcq  = 2'd2,
        StPush = 2'd3
    } cap_state_e;

    // FIFO entry layout is {sof, idx, data}
    function automatic int unsigned entry_width(int unsigned idx_w, int unsigned data_w);
        return 1 + idx_w + data_w;
    endfunction

endpackage

// File: rtl/adc_sample_fifo.sv
// adc_sample_fifo
// Synchronous first-word-fall-through FIFO. rdata always shows the head entry
// (zero while empty). A push while full is accepted only if a pop happens in
// the same cycle.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push, wdata  write request and data
//   pop          remove head entry (ignored while empty)
//   rdata        head entry
//   full, empty  occupancy flags
module adc_sample_fifo #(
    parameter int unsigned WIDTH = 29,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = (cnt_q == CntW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Power-of-two depth: pointers wrap by natural overflow
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) wptr_d = wptr_q + PtrW'(1);
        if (do_pop)  rptr_d = rptr_q + PtrW'(1);
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

    assign rdata = empty ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl
// Takes one ADC sample per scan position once the DAC has written all four
// channels: pulses convert, clocks in one serial word, tags it with the pixel
// index and frame-start flag, and queues it for a valid/ready consumer.
// Ports:
//   rx_spi_sclk_wire      sole clock
//   rst                   asynchronous reset, active-low
//   adc_start             DAC initialised, pixel stream live
//   serial_counter        DAC channel-write count (4 = pixel settled)
//   verti_counter         current scan position
//   loop                  DAC at frame corner, suppresses sampling
//   adc_cnv/cs_n/sck/sdo  ADC convert strobe and 3-wire SPI
//   smp_*                 head-of-FIFO sample stream (valid/ready)
//   ovf_err               sticky: finished sample dropped on full FIFO
//   miss_err              sticky: trigger arrived while busy
module adc_capture_ctrl
    import adc_capture_pkg::*;
#(
    parameter int unsigned DATA_W     = DataWDef,
    parameter int unsigned T_CONV     = TConvDef,
    parameter int unsigned FIFO_DEPTH = FifoDepthDef,
    parameter int unsigned IDX_W      = IdxWDef
) (
    input  logic              rx_spi_sclk_wire,
    input  logic              rst,
    input  logic              adc_start,
    input  logic [3:0]        serial_counter,
    input  logic [31:0]       verti_counter,
    input  logic              loop,
    output logic              adc_cnv,
    output logic              adc_cs_n,
    output logic              adc_sck,
    input  logic              adc_sdo,
    output logic [DATA_W-1:0] smp_data,
    output logic [IDX_W-1:0]  smp_index,
    output logic              smp_sof,
    output logic              smp_valid,
    input  logic              smp_ready,
    output logic              ovf_err,
    output logic              miss_err
);

    localparam int unsigned EntryW   = entry_width(IDX_W, DATA_W);
    localparam int unsigned ConvCntW = $clog2(T_CONV);
    localparam int unsigned BitCntW  = $clog2(2 * DATA_W);

    cap_state_e state_q, state_d;

    logic [2:0]          sync_q;
    logic                trig;
    logic [ConvCntW-1:0] conv_cnt_q, conv_cnt_d;
    logic [BitCntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                sof_q, sof_d;
    logic                ovf_q, ovf_d;
    logic                miss_q, miss_d;
    logic                conv_done, acq_done;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [EntryW-1:0] fifo_wdata, fifo_rdata;

    // sync_q[1] is the synchronised settle flag, sync_q[2] its previous value
    assign trig      = sync_q[1] && !sync_q[2] && adc_start && !loop;
    assign conv_done = (conv_cnt_q == ConvCntW'(T_CONV - 1));
    assign acq_done  = (bit_cnt_q == BitCntW'(2 * DATA_W - 1));

    always_ff @(posedge rx_spi_sclk_wire or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (trig) state_d = StConv;
            StConv:  if (conv_done) state_d = StAcq;
            StAcq:   if (acq_done) state_d = StPush;
            StPush:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Decoded from state so reset forces cs_n high and sck low immediately
    always_comb begin
        adc_cnv  = (state_q == StConv);
        adc_cs_n = (state_q != StAcq);
        adc_sck  = (state_q == StAcq) && bit_cnt_q[0];
    end

    always_comb begin
        conv_cnt_d = '0;
        bit_cnt_d  = '0;
        shift_d    = shift_q;
        idx_d      = idx_q;
        sof_d      = sof_q;
        miss_d     = miss_q | (trig && (state_q != StIdle));
        ovf_d      = ovf_q | ((state_q == StPush) && fifo_full && !fifo_pop);

        if (state_q == StConv && !conv_done) conv_cnt_d = conv_cnt_q + ConvCntW'(1);
        if (state_q == StAcq && !acq_done)   bit_cnt_d  = bit_cnt_q + BitCntW'(1);

        // Even half-cycle count: this edge drives sck 0->1, so sample here
        if (state_q == StAcq && !bit_cnt_q[0]) shift_d = {shift_q[DATA_W-2:0], adc_sdo};

        if (state_q == StIdle && trig) begin
            idx_d   = verti_counter[IDX_W-1:0];
            sof_d   = (verti_counter == 32'd0);
            shift_d = '0;
        end
    end

    always_ff @(posedge rx_spi_sclk_wire or negedge rst) begin
        if (!rst) begin
            sync_q     <= '0;
            conv_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            idx_q      <= '0;
            sof_q      <= 1'b0;
            ovf_q      <= 1'b0;
            miss_q     <= 1'b0;
        end else begin
            sync_q     <= {sync_q[1:0], (serial_counter == 4'd4)};
            conv_cnt_q <= conv_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            sof_q      <= sof_d;
            ovf_q      <= ovf_d;
            miss_q     <= miss_d;
        end
    end

    assign fifo_push  = (state_q == StPush);
    assign fifo_pop   = smp_valid && smp_ready;
    assign fifo_wdata = {sof_q, idx_q, shift_q};

    adc_sample_fifo #(
        .WIDTH (EntryW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (rx_spi_sclk_wire),
        .rst_n (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign smp_valid = !fifo_empty;
    assign smp_sof   = fifo_rdata[EntryW-1];
    assign smp_index = fifo_rdata[DATA_W +: IDX_W];
    assign smp_data  = fifo_rdata[DATA_W-1:0];
    assign ovf_err   = ovf_q;
    assign miss_err  = miss_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl with a behavioural 3-wire ADC model.
module tb_adc_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        adc_start = 1'b1;
    logic [3:0]  serial_counter = 4'd0;
    logic [31:0] verti_counter = 32'd0;
    logic        loop_s = 1'b0;
    logic        adc_cnv, adc_cs_n, adc_sck, adc_sdo;
    logic [15:0] smp_data;
    logic [11:0] smp_index;
    logic        smp_sof, smp_valid;
    logic        smp_ready = 1'b0;
    logic        ovf_err, miss_err;

    int checks = 0;
    int errors = 0;
    int sck_rises = 0;
    int fall_cnt = 0;
    logic [15:0] adc_word = 16'h0000;

    always #5 clk = ~clk;

    adc_capture_ctrl dut (
        .rx_spi_sclk_wire (clk),
        .rst              (rst_n),
        .adc_start        (adc_start),
        .serial_counter   (serial_counter),
        .verti_counter    (verti_counter),
        .loop             (loop_s),
        .adc_cnv          (adc_cnv),
        .adc_cs_n         (adc_cs_n),
        .adc_sck          (adc_sck),
        .adc_sdo          (adc_sdo),
        .smp_data         (smp_data),
        .smp_index        (smp_index),
        .smp_sof          (smp_sof),
        .smp_valid        (smp_valid),
        .smp_ready        (smp_ready),
        .ovf_err          (ovf_err),
        .miss_err         (miss_err)
    );

    // ADC model: MSB valid once cs_n falls, next bit after each sck fall
    always @(posedge adc_sck) sck_rises = sck_rises + 1;
    always @(negedge adc_sck or posedge adc_cs_n) begin
        if (adc_cs_n) fall_cnt = 0;
        else          fall_cnt = fall_cnt + 1;
    end
    assign adc_sdo = (fall_cnt < 16) ? adc_word[15 - fall_cnt] : 1'b0;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        serial_counter = 4'd0;
        smp_ready = 1'b0;
        loop_s = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_pixel(input logic [31:0] pos, input logic lp, input logic [15:0] word);
        @(negedge clk);
        adc_word = word;
        verti_counter = pos;
        loop_s = lp;
        serial_counter = 4'd3;
        @(negedge clk);
        serial_counter = 4'd4;
        repeat (85) @(negedge clk);
        serial_counter = 4'd0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pop_one();
        smp_ready = 1'b1;
        @(negedge clk);
        smp_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (adc_cnv !== 1'b0) begin errors++; $display("FAIL reset_cnv: got %b want 0", adc_cnv); end
        checks++; if (adc_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b want 1", adc_cs_n); end
        checks++; if (adc_sck !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b want 0", adc_sck); end
        checks++; if (smp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", smp_valid); end
        checks++; if (smp_data !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0", smp_data); end
        checks++; if (smp_index !== 12'h0) begin errors++; $display("FAIL reset_index: got %h want 0", smp_index); end
        checks++; if (smp_sof !== 1'b0) begin errors++; $display("FAIL reset_sof: got %b want 0", smp_sof); end
        checks++; if ({ovf_err, miss_err} !== 2'b00) begin errors++; $display("FAIL reset_errs: got %b want 00", {ovf_err, miss_err}); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_pixel();
        int base, cnv_n, early;
        adc_word = 16'hA5C3;
        verti_counter = 32'd5;
        serial_counter = 4'd3;
        @(negedge clk);
        serial_counter = 4'd4;
        base = sck_rises;
        cnv_n = 0;
        early = 0;
        repeat (75) begin
            @(negedge clk);
            if (adc_cnv) cnv_n++;
            if (smp_valid) early++;
        end
        @(negedge clk);
        checks++; if (early !== 0) begin errors++; $display("FAIL single_early_valid: got %0d cycles want 0", early); end
        checks++; if (smp_valid !== 1'b1) begin errors++; $display("FAIL single_valid_74: got %b want 1", smp_valid); end
        checks++; if (cnv_n !== 40) begin errors++; $display("FAIL single_cnv_len: got %0d want 40", cnv_n); end
        checks++; if (sck_rises - base !== 16) begin errors++; $display("FAIL single_sck_rises: got %0d want 16", sck_rises - base); end
        checks++; if (smp_data !== 16'hA5C3) begin errors++; $display("FAIL single_data: got %h want a5c3", smp_data); end
        checks++; if (smp_index !== 12'd5) begin errors++; $display("FAIL single_index: got %0d want 5", smp_index); end
        checks++; if (smp_sof !== 1'b0) begin errors++; $display("FAIL single_sof: got %b want 0", smp_sof); end
        checks++; if (miss_err !== 1'b0) begin errors++; $display("FAIL single_miss: got %b want 0", miss_err); end
        pop_one();
        checks++; if (smp_valid !== 1'b0) begin errors++; $display("FAIL single_drained: got %b want 0", smp_valid); end
        serial_counter = 4'd0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_frame_start();
        int base;
        run_pixel(32'd0, 1'b0, 16'h1234);
        checks++; if (smp_valid !== 1'b1) begin errors++; $display("FAIL sof_valid: got %b want 1", smp_valid); end
        checks++; if (smp_sof !== 1'b1) begin errors++; $display("FAIL sof_flag: got %b want 1", smp_sof); end
        checks++; if (smp_index !== 12'd0) begin errors++; $display("FAIL sof_index: got %0d want 0", smp_index); end
        checks++; if (smp_data !== 16'h1234) begin errors++; $display("FAIL sof_data: got %h want 1234", smp_data); end
        pop_one();
        base = sck_rises;
        run_pixel(32'd1999, 1'b1, 16'hFFFF);
        checks++; if (smp_valid !== 1'b0) begin errors++; $display("FAIL corner_no_capture: got valid %b want 0", smp_valid); end
        checks++; if (sck_rises - base !== 0) begin errors++; $display("FAIL corner_sck: got %0d want 0", sck_rises - base); end
        checks++; if (miss_err !== 1'b0) begin errors++; $display("FAIL corner_miss: got %b want 0", miss_err); end
        loop_s = 1'b0;
    endtask

    task automatic test_back_pressure();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            run_pixel(32'(i), 1'b0, 16'h1000 + 16'(i));
            if (i == 3) begin
                checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL bp_ovf_before: got %b want 0", ovf_err); end
            end
        end
        checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL bp_ovf_after: got %b want 1", ovf_err); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (smp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", i, smp_valid); end
            checks++; if (smp_index !== 12'(i)) begin errors++; $display("FAIL bp_index[%0d]: got %0d want %0d", i, smp_index, i); end
            checks++; if (smp_data !== 16'h1000 + 16'(i)) begin errors++; $display("FAIL bp_data[%0d]: got %h want %h", i, smp_data, 16'h1000 + 16'(i)); end
            checks++; if (smp_sof !== (i == 0)) begin errors++; $display("FAIL bp_sof[%0d]: got %b want %b", i, smp_sof, (i == 0)); end
            pop_one();
        end
        checks++; if (smp_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", smp_valid); end
    endtask

    task automatic test_busy_trigger();
        apply_reset();
        @(negedge clk);
        adc_word = 16'h0F0F;
        verti_counter = 32'd7;
        serial_counter = 4'd3;
        @(negedge clk);
        serial_counter = 4'd4;
        repeat (4) @(negedge clk);
        serial_counter = 4'd0;
        repeat (6) @(negedge clk);
        serial_counter = 4'd4;
        repeat (80) @(negedge clk);
        serial_counter = 4'd0;
        repeat (5) @(negedge clk);
        checks++; if (miss_err !== 1'b1) begin errors++; $display("FAIL busy_miss: got %b want 1", miss_err); end
        checks++; if (smp_valid !== 1'b1) begin errors++; $display("FAIL busy_valid: got %b want 1", smp_valid); end
        checks++; if (smp_index !== 12'd7) begin errors++; $display("FAIL busy_index: got %0d want 7", smp_index); end
        checks++; if (smp_data !== 16'h0F0F) begin errors++; $display("FAIL busy_data: got %h want 0f0f", smp_data); end
        pop_one();
        checks++; if (smp_valid !== 1'b0) begin errors++; $display("FAIL busy_single_word: got %b want 0", smp_valid); end
    endtask

    task automatic test_full_pop();
        logic seen_low, found;
        apply_reset();
        for (int i = 0; i < 4; i++) run_pixel(32'(10 + i), 1'b0, 16'h2000 + 16'(i));
        @(negedge clk);
        adc_word = 16'h2004;
        verti_counter = 32'd14;
        serial_counter = 4'd3;
        @(negedge clk);
        serial_counter = 4'd4;
        seen_low = 1'b0;
        found = 1'b0;
        // First negedge with cs_n high after ACQ is the PUSH cycle
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (seen_low && adc_cs_n) begin
                found = 1'b1;
                break;
            end
            if (!adc_cs_n) seen_low = 1'b1;
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL fullpop_push_seen: got %b want 1", found); end
        pop_one();
        serial_counter = 4'd0;
        repeat (2) @(negedge clk);
        checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL fullpop_ovf: got %b want 0", ovf_err); end
        for (int i = 1; i < 5; i++) begin
            checks++; if (smp_valid !== 1'b1) begin errors++; $display("FAIL fullpop_valid[%0d]: got %b want 1", i, smp_valid); end
            checks++; if (smp_index !== 12'(10 + i)) begin errors++; $display("FAIL fullpop_index[%0d]: got %0d want %0d", i, smp_index, 10 + i); end
            checks++; if (smp_data !== 16'h2000 + 16'(i)) begin errors++; $display("FAIL fullpop_data[%0d]: got %h want %h", i, smp_data, 16'h2000 + 16'(i)); end
            pop_one();
        end
        checks++; if (smp_valid !== 1'b0) begin errors++; $display("FAIL fullpop_count4: got valid %b want 0", smp_valid); end
    endtask

    task automatic test_reset_mid_acq();
        int base, base2, cs_low;
        logic found;
        apply_reset();
        @(negedge clk);
        adc_word = 16'hBEEF;
        verti_counter = 32'd20;
        serial_counter = 4'd3;
        @(negedge clk);
        serial_counter = 4'd4;
        base = sck_rises;
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (sck_rises - base >= 8) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL midacq_reach_bit7: got %b want 1", found); end
        checks++; if (adc_cs_n !== 1'b0) begin errors++; $display("FAIL midacq_cs_active: got %b want 0", adc_cs_n); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (adc_cs_n !== 1'b1) begin errors++; $display("FAIL midacq_cs_n: got %b want 1", adc_cs_n); end
        checks++; if (adc_sck !== 1'b0) begin errors++; $display("FAIL midacq_sck: got %b want 0", adc_sck); end
        checks++; if (smp_valid !== 1'b0) begin errors++; $display("FAIL midacq_fifo_empty: got %b want 0", smp_valid); end
        serial_counter = 4'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base2 = sck_rises;
        cs_low = 0;
        repeat (90) begin
            @(negedge clk);
            if (!adc_cs_n) cs_low++;
        end
        checks++; if (smp_valid !== 1'b0) begin errors++; $display("FAIL midacq_no_word: got %b want 0", smp_valid); end
        checks++; if (cs_low !== 0) begin errors++; $display("FAIL midacq_no_restart: got %0d low cycles want 0", cs_low); end
        checks++; if (sck_rises - base2 !== 0) begin errors++; $display("FAIL midacq_sck_idle: got %0d want 0", sck_rises - base2); end
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_frame_start();
        test_back_pressure();
        test_busy_trigger();
        test_full_pop();
        test_reset_mid_acq();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
